divu_seq: RTL and testbench
===========================

# divu_seq

Sequential unsigned restoring divider: the divide-side counterpart of the shift-add multiplier `Control` unit. It produces one quotient bit per clock by shift-and-trial-subtract, and raises `Ready` when `Quotient` and `Remainder` are valid. It contains its own control FSM, iteration counter and remainder/quotient datapath. It sits beside the multiplier in the arithmetic unit and uses the same level-sensitive `Run` / `Ready` handshake.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width in bits (≥ 2).
- `clk`  input  1: clock; all state updates on the rising edge.
- `Reset`  input  1: synchronous, active-high reset.
- `Run`  input  1: start request, level-sensitive.
- `Dividend`  input  WIDTH: numerator, sampled only on the start edge.
- `Divisor`  input  WIDTH: denominator, sampled only on the start edge.
- `Quotient`  output  WIDTH: registered quotient.
- `Remainder`  output  WIDTH: registered remainder.
- `Ready`  output  1: result valid; registered, high only in DONE.
- `DivZero`  output  1: divisor of the current/last operation was zero; registered.

## Operation
- States:
  - IDLE: waiting for a start.
  - CALC: iterating.
  - DONE: result held, `Ready`=1.
- IDLE & `Run`=1 is the start edge:
  - `R` ← 0, `Q` ← `Dividend`, `D` ← `Divisor`, count ← 0.
  - `DivZero` ← (`Divisor`==0).
  - Go to CALC.
- CALC, each edge:
  - `S` = {`R`,`Q[WIDTH-1]`}, WIDTH+1 bits.
  - `T` = `S` − {1'b0,`D`}, WIDTH+1 bits.
  - If `S` ≥ `D`: `R` ← `T[WIDTH-1:0]`, `Q` ← {`Q[WIDTH-2:0]`,1}.
  - Else: `R` ← `S[WIDTH-1:0]`, `Q` ← {`Q[WIDTH-2:0]`,0}.
  - count++.
  - On the iteration with count==WIDTH−1, go to DONE.
- The compare is on WIDTH+1 bits. The shifted remainder can exceed WIDTH bits when `D` is large, and truncating it is a bug.
- DONE: `Quotient`=`Q`, `Remainder`=`R`, `Ready`=1.
  - Stay while `Run`=1; the next operation needs `Run` to drop first.
  - `Run`=0 → IDLE.
- IDLE keeps `Quotient` / `Remainder` / `DivZero` from the last operation. `Ready`=0.
- `Quotient` and `Remainder` are driven directly from the `Q` and `R` registers. They change during CALC and are meaningful only while `Ready`=1.
- Result identity: `Dividend` = `Quotient`·`Divisor` + `Remainder`, with `Remainder` < `Divisor` (for `Divisor` ≠ 0).

## Timing
- Reset values: `Ready`=0, `DivZero`=0, `Quotient`=0, `Remainder`=0, state=IDLE, count=0.
- Latency with a nonzero divisor:
  - Start edge E0.
  - Iterations on E1..E_WIDTH.
  - `Ready` is high after E_WIDTH, i.e. WIDTH cycles after the start edge (32 for default).
- Busy window: `Run` transitions and operand changes during CALC are ignored.
- Re-arm:
  - After `Run` drops in DONE, `Ready` falls on the next edge.
  - A new start needs `Run`=1 sampled in IDLE, so back-to-back operations take at least WIDTH+2 cycles.
- Reset priority: `Reset`=1 on any edge overrides everything, including mid-CALC and a simultaneous `Run`=1. All outputs return to reset values on that edge. An operation aborted this way produces no `Ready`.
- `Run` high on the edge that `Reset` deasserts: no start. The start happens on the first edge where `Reset`=0 and `Run`=1.

## Configuration
- Macro: `DIVU_DIVZERO_EN`.
- Defined: a start with `Divisor`==0 goes IDLE → DONE on the start edge.
  - `Quotient` = all ones, `Remainder` = `Dividend`, `DivZero`=1.
  - `Ready` is high one cycle after start.
- Not defined: no fast path. The zero divisor runs the full WIDTH iterations.
  - The algorithm naturally yields `Quotient` = all ones, `Remainder` = `Dividend`.
  - `DivZero` is still set from the sampled divisor.
- Result values are identical in both builds; only latency differs.

## Test plan
- Reset, then `Dividend`=100, `Divisor`=7, `Run`=1 → `Ready` rises exactly 32 cycles after the start edge, `Quotient`=14, `Remainder`=2, `DivZero`=0.
- `Dividend`=0xFFFFFFFF with `Divisor`=0xFFFFFFFF, then separately with `Divisor`=1:
  - First → `Quotient`=1, `Remainder`=0.
  - Second → `Quotient`=0xFFFFFFFF, `Remainder`=0.
  - Covers the WIDTH+1-bit compare.
- `Dividend`=5, `Divisor`=9 → `Quotient`=0, `Remainder`=5.
  - Then hold `Run`=1 for 10 more cycles → `Ready` stays 1 with no restart.
  - Drop `Run` → `Ready`=0 on the next edge, outputs held.
- `Divisor`=0, `Dividend`=0x1234 → `Quotient`=0xFFFFFFFF, `Remainder`=0x1234, `DivZero`=1.
  - `Ready` after 1 cycle with `DIVU_DIVZERO_EN`, after 32 cycles without it.
- Start 1000/3, assert `Reset` 10 cycles in → all outputs 0, no `Ready`.
  - Then start 1000/3 again → `Quotient`=333, `Remainder`=1 after 32 cycles.

Source files
------------

// File: rtl/divu_seq.sv
// divu_seq: sequential unsigned restoring divider.
//
// Produces one quotient bit per clock by shift-and-trial-subtract. It uses a
// level-sensitive Run/Ready handshake:
//   - Run high in IDLE starts an operation.
//   - Ready stays high in DONE until Run drops.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   Reset      in   synchronous active-high reset
//   Run        in   start request (level-sensitive)
//   Dividend   in   WIDTH  numerator, sampled on the start edge
//   Divisor    in   WIDTH  denominator, sampled on the start edge
//   Quotient   out  WIDTH  quotient register, valid while Ready=1
//   Remainder  out  WIDTH  remainder register, valid while Ready=1
//   Ready      out  result valid (registered, high only in DONE)
//   DivZero    out  divisor of the current/last operation was zero
//
// Configuration macro:
//   DIVU_DIVZERO_EN
//     Defined: a zero divisor completes on the start edge (IDLE -> DONE).
//     Undefined: a zero divisor runs the full WIDTH iterations.
//     Both builds give identical results.

module divu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Ready,
  output logic             DivZero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [CntW-1:0]  r_cnt;
  logic             r_ready;
  logic             r_divzero;

  logic [WIDTH:0]   w_s;
  logic             w_ge;
  logic [WIDTH-1:0] w_t;

  // The shifted partial remainder needs WIDTH+1 bits. When the divisor has
  // its MSB set, S can exceed 2^WIDTH-1, and a WIDTH-bit compare would be
  // wrong. Only the low WIDTH bits of the difference are kept: when S >= D,
  // the difference is below D and therefore fits.
  assign w_s  = {r_r, r_q[WIDTH-1]};
  assign w_ge = (w_s >= {1'b0, r_d});
  assign w_t  = w_s[WIDTH-1:0] - r_d;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= StIdle;
      r_q       <= '0;
      r_r       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (Run) begin
            r_divzero <= (Divisor == '0);
            r_d       <= Divisor;
            r_cnt     <= '0;
`ifdef DIVU_DIVZERO_EN
            if (Divisor == '0) begin
              // Fast path: the iteration would yield exactly these values.
              r_q     <= '1;
              r_r     <= Dividend;
              r_ready <= 1'b1;
              r_state <= StDone;
            end else begin
              r_q     <= Dividend;
              r_r     <= '0;
              r_state <= StCalc;
            end
`else
            r_q     <= Dividend;
            r_r     <= '0;
            r_state <= StCalc;
`endif
          end
        end

        StCalc: begin
          r_r   <= w_ge ? w_t : w_s[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            r_ready <= 1'b1;
            r_state <= StDone;
          end
        end

        StDone: begin
          // Hold the result until the requester drops Run.
          if (!Run) begin
            r_ready <= 1'b0;
            r_state <= StIdle;
          end
        end

        default: begin
          r_ready <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign Quotient  = r_q;
  assign Remainder = r_r;
  assign Ready     = r_ready;
  assign DivZero   = r_divzero;

endmodule

// File: tb/tb_divu_seq.sv
// Self-checking bench for divu_seq (WIDTH=32).
//
// Structure:
//   - A behavioural model predicts Ready, DivZero, Quotient and Remainder on
//     every cycle. It computes results with plain / and %, and latency as a
//     cycle count.
//   - Directed operations pin the model with hand-computed literals.
//   - Randomised operations scramble the inputs during the busy window.

module tb_divu_seq;

  localparam int unsigned WIDTH = 32;
`ifdef DIVU_DIVZERO_EN
  localparam bit FastZero = 1'b1;
`else
  localparam bit FastZero = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Run = 1'b0;
  logic [31:0] Dividend = '0;
  logic [31:0] Divisor = '0;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        Ready;
  logic        DivZero;

  divu_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .Run      (Run),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Ready    (Ready),
    .DivZero  (DivZero)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model.
  //   m_phase: 0 = waiting for a start, 1 = busy, 2 = result presented.
  //   m_cd:    edges left before the result appears.
  //   m_vals:  Quotient/Remainder are predictable this cycle.
  int          m_phase;
  int          m_cd;
  logic [31:0] m_q;
  logic [31:0] m_r;
  logic        m_dz;
  logic        m_ready;
  logic        m_vals;

  always @(posedge clk) begin
    if (Reset) begin
      m_phase <= 0;
      m_cd    <= 0;
      m_q     <= '0;
      m_r     <= '0;
      m_dz    <= 1'b0;
      m_ready <= 1'b0;
      m_vals  <= 1'b1;
    end else begin
      case (m_phase)
        0: begin
          if (Run) begin
            m_dz <= (Divisor == 0);
            m_q  <= (Divisor == 0) ? 32'hFFFF_FFFF : Dividend / Divisor;
            m_r  <= (Divisor == 0) ? Dividend : Dividend % Divisor;
            if (FastZero && Divisor == 0) begin
              m_phase <= 2;
              m_ready <= 1'b1;
              m_vals  <= 1'b1;
            end else begin
              m_phase <= 1;
              m_cd    <= WIDTH;
              m_vals  <= 1'b0;
            end
          end
        end
        1: begin
          m_cd <= m_cd - 1;
          if (m_cd == 1) begin
            m_phase <= 2;
            m_ready <= 1'b1;
            m_vals  <= 1'b1;
          end
        end
        2: begin
          if (!Run) begin
            m_phase <= 0;
            m_ready <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare process: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", Ready, m_ready);
      check("divzero", DivZero, m_dz);
      if (m_vals) begin
        check("quotient", Quotient, m_q);
        check("remainder", Remainder, m_r);
      end
    end
  end

  // Waits for Ready. lat counts falling edges after the start request, so
  // lat=1 means Ready became visible right after the start edge.
  task automatic wait_ready(input bit scramble, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!Ready && scramble) begin
        Dividend = $urandom;
        Divisor  = $urandom;
        Run      = 1'($urandom_range(0, 1));
      end
    end while (!Ready && lat < 200);
    if (!Ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: Ready still 0 after %0d cycles, expected 1", lat);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                        output int lat);
    @(negedge clk);
    Dividend = a;
    Divisor  = b;
    Run      = 1'b1;
    wait_ready(scramble, lat);
  endtask

  task automatic end_op();
    @(negedge clk);
    Run = 1'b0;
    @(negedge clk);
    check("ready_drop", Ready, 1'b0);
  endtask

  function automatic int exp_lat(input logic [31:0] b);
    return (FastZero && b == 0) ? 1 : WIDTH + 1;
  endfunction

  initial begin
    int lat;
    logic [31:0] a, b;
    logic [63:0] prod;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_quotient", Quotient, 32'd0);
    check("rst_remainder", Remainder, 32'd0);
    check("rst_ready", Ready, 1'b0);
    check("rst_divzero", DivZero, 1'b0);
    Reset = 1'b0;

    // 100 / 7
    run_op(32'd100, 32'd7, 1'b0, lat);
    check("lat_100_7", lat, 33);
    check("q_100_7", Quotient, 32'd14);
    check("r_100_7", Remainder, 32'd2);
    check("dz_100_7", DivZero, 1'b0);
    end_op();

    // Wide compare cases
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("q_max_max", Quotient, 32'd1);
    check("r_max_max", Remainder, 32'd0);
    end_op();
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    check("q_max_1", Quotient, 32'hFFFF_FFFF);
    check("r_max_1", Remainder, 32'd0);
    end_op();

    // Divisor larger than dividend, then hold Run
    run_op(32'd5, 32'd9, 1'b0, lat);
    check("q_5_9", Quotient, 32'd0);
    check("r_5_9", Remainder, 32'd5);
    repeat (10) begin
      @(negedge clk);
      check("hold_ready", Ready, 1'b1);
    end
    @(negedge clk);
    Run = 1'b0;
    @(negedge clk);
    check("drop_ready", Ready, 1'b0);
    check("drop_q_held", Quotient, 32'd0);
    check("drop_r_held", Remainder, 32'd5);
    @(negedge clk);

    // Divide by zero
    run_op(32'h1234, 32'd0, 1'b0, lat);
    check("lat_div0", lat, FastZero ? 1 : 33);
    check("q_div0", Quotient, 32'hFFFF_FFFF);
    check("r_div0", Remainder, 32'h1234);
    check("dz_div0", DivZero, 1'b1);
    end_op();

    // Abort with reset mid-operation.
    // Run stays high through reset and its release.
    @(negedge clk);
    Dividend = 32'd1000;
    Divisor  = 32'd3;
    Run      = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_not_ready", Ready, 1'b0);
    Reset = 1'b1;
    @(negedge clk);
    check("abort_q", Quotient, 32'd0);
    check("abort_r", Remainder, 32'd0);
    check("abort_ready", Ready, 1'b0);
    check("abort_dz", DivZero, 1'b0);
    @(negedge clk);
    Reset = 1'b0;
    wait_ready(1'b0, lat);
    check("lat_after_rst", lat, 33);
    check("q_1000_3", Quotient, 32'd333);
    check("r_1000_3", Remainder, 32'd1);
    end_op();

    // Randomised operations
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0;
        3: begin
          a = a >> $urandom_range(1, 31);
          b = a + 32'($urandom_range(1, 1000));
        end
        default: b = $urandom | 32'h8000_0000;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), lat);
      check("rand_lat", lat, exp_lat(b));
      if (b != 0) begin
        prod = 64'(Quotient) * 64'(b) + 64'(Remainder);
        check("rand_identity", prod, {32'd0, a});
        check("rand_rem_lt_div", (Remainder < b), 1'b1);
      end
      end_op();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
